// File: rtl/instr_fetch_queue_if.sv
// Handshake bundle between the IF stage, the fetch queue and the ID stage.
// master drives the fetch offer and consume/flush controls; slave is the queue itself.
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_pc;
  logic [WIDTH-1:0] in_instr;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_instr;
  logic             out_adel;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_adel, count, full, empty
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_adel, count, full, empty
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// First-word-fall-through queue of fetched {adel, pc, instr} entries between IF and ID.
// Flush empties the queue in one cycle; misaligned PCs are tagged with an address-error flag.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] pc_mem_r    [DEPTH];
  logic [WIDTH-1:0] instr_mem_r [DEPTH];
  logic [DEPTH-1:0] adel_mem_r;

  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [PW-1:0] rd_ptr_next_s, wr_ptr_next_s;
  logic [CW-1:0] count_r, count_next_s;
  logic          full_r, empty_r;
  logic          full_next_s, empty_next_s;
  logic          push_s, pop_s;

  function automatic logic pc_misaligned(input logic [WIDTH-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  // Full blocks pushes even when a pop happens, so in_ready never depends on out_ready.
  assign push_s = q.in_valid & ~full_r & ~q.flush;
  assign pop_s  = ~empty_r & q.out_ready & ~q.flush;

  // Next-state computation for pointers, occupancy and status flags.
  always_comb begin
    rd_ptr_next_s = rd_ptr_r;
    wr_ptr_next_s = wr_ptr_r;
    count_next_s  = count_r;
    if (q.flush) begin
      rd_ptr_next_s = PTR_ZERO;
      wr_ptr_next_s = PTR_ZERO;
      count_next_s  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_next_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_next_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CNT_ONE;
        2'b01:   count_next_s = count_r - CNT_ONE;
        default: count_next_s = count_r;
      endcase
    end
    full_next_s  = (count_next_s == CNT_DEPTH);
    empty_next_s = (count_next_s == CNT_ZERO);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      rd_ptr_r <= rd_ptr_next_s;
      wr_ptr_r <= wr_ptr_next_s;
      count_r  <= count_next_s;
      full_r   <= full_next_s;
      empty_r  <= empty_next_s;
    end
  end

  // Entry storage; cleared on reset so the head reads zero, left untouched by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {WIDTH{1'b0}};
        instr_mem_r[i] <= {WIDTH{1'b0}};
      end
      adel_mem_r <= {DEPTH{1'b0}};
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= q.in_pc;
      instr_mem_r[wr_ptr_r] <= q.in_instr;
      adel_mem_r[wr_ptr_r]  <= pc_misaligned(q.in_pc);
    end
  end

  assign q.in_ready  = ~full_r;
  assign q.out_valid = ~empty_r;
  assign q.out_pc    = pc_mem_r[rd_ptr_r];
  assign q.out_instr = instr_mem_r[rd_ptr_r];
  assign q.out_adel  = adel_mem_r[rd_ptr_r];
  assign q.count     = count_r;
  assign q.full      = full_r;
  assign q.empty     = empty_r;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a reference queue is updated on every driven cycle
// and each DUT pop is compared against the popped model entry.
module tb_instr_fetch_queue;
  typedef logic [64:0] entry_t;  // {adel, pc, instr}

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  entry_t exp_q[$];

  instr_fetch_queue_if #(.DEPTH(4), .WIDTH(32)) ifc ();

  instr_fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .q   (ifc)
  );

  always #5 clk = ~clk;

  // Drive one cycle, mirror it in the model, and report the head the DUT offered if it popped.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl,
                      output logic popped, output entry_t got, output entry_t exp);
    logic m_push, m_pop;
    ifc.in_valid  = v;
    ifc.in_pc     = pc;
    ifc.in_instr  = ins;
    ifc.out_ready = rdy;
    ifc.flush     = fl;
    m_push = v && (exp_q.size() < 4) && !fl;
    m_pop  = rdy && (exp_q.size() > 0) && !fl;
    popped = m_pop;
    got    = {ifc.out_adel, ifc.out_pc, ifc.out_instr};
    exp    = m_pop ? exp_q[0] : 65'd0;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({(pc[1:0] != 2'b00), pc, ins});
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.flush     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (ifc.count !== 3'd0) $display("FAIL rst_count: got %0d want 0", ifc.count); else pass_cnt++;
    chk_cnt++; if ({ifc.empty, ifc.full, ifc.in_ready, ifc.out_valid} !== 4'b1010)
      $display("FAIL rst_flags: got e/f/ir/ov=%b want 1010", {ifc.empty, ifc.full, ifc.in_ready, ifc.out_valid});
    else pass_cnt++;
    chk_cnt++; if (ifc.out_pc !== 32'h0) $display("FAIL rst_out_pc: got %h want 0", ifc.out_pc); else pass_cnt++;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic p; entry_t g, e;
    step(1'b1, 32'hbfc00000, 32'h3c1d8001, 1'b0, 1'b0, p, g, e);
    chk_cnt++; if (ifc.out_valid !== 1'b1) $display("FAIL basic_latency: out_valid got %b want 1", ifc.out_valid); else pass_cnt++;
    step(1'b1, 32'hbfc00004, 32'h27bdfff0, 1'b0, 1'b0, p, g, e);
    chk_cnt++; if (ifc.count !== 3'd2) $display("FAIL basic_count: got %0d want 2", ifc.count); else pass_cnt++;
    chk_cnt++; if ({ifc.out_adel, ifc.out_pc, ifc.out_instr} !== {1'b0, 32'hbfc00000, 32'h3c1d8001})
      $display("FAIL basic_head: got %b/%h/%h want 0/bfc00000/3c1d8001", ifc.out_adel, ifc.out_pc, ifc.out_instr);
    else pass_cnt++;
  endtask

  task automatic test_full();
    logic p; entry_t g, e;
    step(1'b1, 32'hbfc00008, 32'h00000008, 1'b0, 1'b0, p, g, e);
    step(1'b1, 32'hbfc0000c, 32'h0000000c, 1'b0, 1'b0, p, g, e);
    chk_cnt++; if ({ifc.full, ifc.in_ready} !== 2'b10)
      $display("FAIL full_flags: got full/in_ready=%b want 10", {ifc.full, ifc.in_ready}); else pass_cnt++;
    step(1'b1, 32'hdeadbeec, 32'hdeadbeef, 1'b0, 1'b0, p, g, e);
    chk_cnt++; if (ifc.count !== 3'd4) $display("FAIL full_overflow_count: got %0d want 4", ifc.count); else pass_cnt++;
    // Pop together with a push while full: the push must still be refused.
    step(1'b1, 32'hdeadbef0, 32'hdeadbeef, 1'b1, 1'b0, p, g, e);
    chk_cnt++; if (g !== e) $display("FAIL full_pop0: got %h want %h", g, e); else pass_cnt++;
    chk_cnt++; if (e[63:32] !== 32'hbfc00000) $display("FAIL full_order0: model head %h want bfc00000", e[63:32]); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
      chk_cnt++; if (g !== e) $display("FAIL full_pop%0d: got %h want %h", i + 1, g, e); else pass_cnt++;
    end
    chk_cnt++; if ({ifc.empty, ifc.out_valid, ifc.count} !== {2'b10, 3'd0})
      $display("FAIL full_drained: got empty=%b out_valid=%b count=%0d", ifc.empty, ifc.out_valid, ifc.count);
    else pass_cnt++;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
    chk_cnt++; if (ifc.count !== 3'd0) $display("FAIL pop_empty_count: got %0d want 0", ifc.count); else pass_cnt++;
  endtask

  task automatic test_push_pop();
    logic p; entry_t g, e;
    logic [31:0] pc;
    step(1'b1, 32'hbfc00010, 32'h11111111, 1'b0, 1'b0, p, g, e);
    step(1'b1, 32'hbfc00014, 32'h22222222, 1'b0, 1'b0, p, g, e);
    step(1'b1, 32'hbfc00018, 32'h33333333, 1'b1, 1'b0, p, g, e);
    chk_cnt++; if (g !== e) $display("FAIL pp_pop: got %h want %h", g, e); else pass_cnt++;
    chk_cnt++; if (ifc.count !== 3'd2) $display("FAIL pp_count: got %0d want 2", ifc.count); else pass_cnt++;
    chk_cnt++; if (ifc.out_pc !== 32'hbfc00014) $display("FAIL pp_head: got %h want bfc00014", ifc.out_pc); else pass_cnt++;
    for (int i = 0; i < 14; i++) begin
      pc = 32'hbfc01000 + 32'(i * 4) + 32'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)) | (i < 2 ? 1'b1 : 1'b0), pc, $urandom,
           1'($urandom_range(0, 1)), 1'b0, p, g, e);
      if (p) begin
        chk_cnt++; if (g !== e) $display("FAIL mix_pop%0d: got %h want %h", i, g, e); else pass_cnt++;
      end
      chk_cnt++; if (ifc.count !== 3'(exp_q.size()))
        $display("FAIL mix_count%0d: got %0d want %0d", i, ifc.count, exp_q.size()); else pass_cnt++;
    end
    while (exp_q.size() > 0) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
      chk_cnt++; if (g !== e) $display("FAIL drain_pop: got %h want %h", g, e); else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    logic p; entry_t g, e;
    for (int i = 0; i < 3; i++) step(1'b1, 32'hbfc00200 + 32'(i * 4), 32'h0a0a0000 + 32'(i), 1'b0, 1'b0, p, g, e);
    chk_cnt++; if (ifc.count !== 3'd3) $display("FAIL flush_pre_count: got %0d want 3", ifc.count); else pass_cnt++;
    step(1'b1, 32'hbfc00300, 32'hbad00bad, 1'b1, 1'b1, p, g, e);
    chk_cnt++; if ({ifc.count, ifc.empty, ifc.out_valid} !== {3'd0, 2'b10})
      $display("FAIL flush_state: got count=%0d empty=%b out_valid=%b want 0/1/0", ifc.count, ifc.empty, ifc.out_valid);
    else pass_cnt++;
    step(1'b1, 32'hbfc00400, 32'h12345678, 1'b0, 1'b0, p, g, e);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, g, e);
    chk_cnt++; if (g !== e || g[63:32] !== 32'hbfc00400)
      $display("FAIL flush_next_head: got %h want %h", g, e); else pass_cnt++;
  endtask

  task automatic test_adel();
    logic p; entry_t g, e;
    step(1'b1, 32'hbfc00382, 32'h8c820000, 1'b0, 1'b0, p, g, e);
    chk_cnt++; if (ifc.out_adel !== 1'b1) $display("FAIL adel_set: got %b want 1", ifc.out_adel); else pass_cnt++;
    step(1'b1, 32'hbfc00380, 32'h8c820004, 1'b1, 1'b0, p, g, e);
    chk_cnt++; if (g !== e) $display("FAIL adel_pop: got %h want %h", g, e); else pass_cnt++;
    chk_cnt++; if ({ifc.out_adel, ifc.out_pc} !== {1'b0, 32'hbfc00380})
      $display("FAIL adel_clear: got %b/%h want 0/bfc00380", ifc.out_adel, ifc.out_pc); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic p; entry_t g, e;
    step(1'b1, 32'hbfc00500, 32'h55555555, 1'b0, 1'b0, p, g, e);
    step(1'b1, 32'hbfc00504, 32'h66666666, 1'b0, 1'b0, p, g, e);
    chk_cnt++; if (ifc.count !== 3'd3) $display("FAIL areset_pre_count: got %0d want 3", ifc.count); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if ({ifc.count, ifc.out_valid, ifc.in_ready} !== {3'd0, 2'b01})
      $display("FAIL areset_state: got count=%0d out_valid=%b in_ready=%b", ifc.count, ifc.out_valid, ifc.in_ready);
    else pass_cnt++;
    chk_cnt++; if (ifc.out_pc !== 32'h0) $display("FAIL areset_out_pc: got %h want 0", ifc.out_pc); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    ifc.flush = 1'b0; ifc.in_valid = 1'b0; ifc.in_pc = 32'h0; ifc.in_instr = 32'h0; ifc.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_push_pop();
    test_flush();
    test_adel();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
